// File: rtl/io_cmd_bridge.sv
// rtl/io_cmd_bridge.sv - UART byte-stream command bridge for board switches and LEDs
// Debounced switch capture, framed LED/mode/read commands, auto-report and error replies.
module io_cmd_bridge #(
    parameter int SW_WIDTH        = 8,
    parameter int LED_WIDTH       = 8,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int TIMEOUT_CYCLES  = 65536
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [SW_WIDTH-1:0]  sw_in,
    output logic [LED_WIDTH-1:0] leds,
    input  logic [7:0]           rx_data,
    input  logic                 rx_valid,
    output logic [7:0]           tx_data,
    output logic                 tx_start,
    input  logic                 tx_busy,
    output logic [1:0]           mode,
    output logic                 cmd_err
);
    localparam int SW_BYTES  = (SW_WIDTH + 7) / 8;
    localparam int LED_BYTES = (LED_WIDTH + 7) / 8;

    localparam logic [31:0] DEB_LIM  = DEBOUNCE_CYCLES;
    localparam logic [31:0] TO_LIM   = TIMEOUT_CYCLES;
    localparam logic [1:0]  LAST_IDX = 2'(LED_BYTES - 1);
    localparam logic [2:0]  PAY_LEN  = 3'(SW_BYTES);

    localparam logic [7:0] OP_LED  = 8'hA0;
    localparam logic [7:0] OP_RD   = 8'hA1;
    localparam logic [7:0] OP_MODE = 8'hA2;
    localparam logic [7:0] RPL_ERR = 8'hEE;
    localparam logic [7:0] RPL_RD  = 8'hB1;
    localparam logic [7:0] RPL_RPT = 8'hB0;

    typedef enum logic [1:0] {P_IDLE, P_LED, P_MODE} p_state_t;
    typedef enum logic [1:0] {T_IDLE, T_LAUNCH, T_WAIT} t_state_t;

    function automatic logic [LED_WIDTH-1:0] sw_to_led(input logic [SW_WIDTH-1:0] s);
        sw_to_led = '0;
        for (int i = 0; i < LED_WIDTH && i < SW_WIDTH; i++)
            sw_to_led[i] = s[i];
    endfunction

    function automatic logic [SW_BYTES*8-1:0] sw_to_payload(input logic [SW_WIDTH-1:0] s);
        sw_to_payload = '0;
        sw_to_payload[SW_WIDTH-1:0] = s;
    endfunction

    logic [SW_WIDTH-1:0]  sw_meta, sw_sync, sw_prev, sw_deb;
    logic [31:0]          deb_cnt, deb_next;
    logic                 deb_load;

    logic [LED_WIDTH-1:0] led_reg, led_buf, led_next;
    logic [1:0]           byte_idx;
    logic [31:0]          to_cnt;
    p_state_t             p_state;

    t_state_t             t_state;
    logic [SW_BYTES*8-1:0] snap;
    logic [2:0]           tx_left;
    logic                 err_pending, rd_pending, rpt_pending;
    logic                 idle_byte, err_set, rd_set, rpt_set;

    // A fresh sw_sync value counts as its own first stable cycle.
    always_comb begin
        deb_next = (sw_sync != sw_prev) ? 32'd1 : deb_cnt + 32'd1;
        deb_load = (sw_sync != sw_deb) && (deb_next >= DEB_LIM);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_meta <= '0;
            sw_sync <= '0;
            sw_prev <= '0;
            sw_deb  <= '0;
            deb_cnt <= '0;
        end else begin
            sw_meta <= sw_in;
            sw_sync <= sw_meta;
            sw_prev <= sw_sync;
            if (sw_sync == sw_deb) begin
                deb_cnt <= '0;
            end else if (deb_load) begin
                sw_deb  <= sw_sync;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_next;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            leds <= '0;
        else
            leds <= mode[1] ? (led_reg | sw_to_led(sw_deb)) : led_reg;
    end

    // Each LED byte only overwrites its own bit lane; lanes past LED_WIDTH fall away.
    always_comb begin
        led_next = led_buf;
        for (int i = 0; i < LED_WIDTH; i++)
            if (byte_idx == 2'(i / 8))
                led_next[i] = rx_data[i % 8];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_state  <= P_IDLE;
            byte_idx <= '0;
            led_buf  <= '0;
            led_reg  <= '0;
            to_cnt   <= '0;
            mode     <= 2'b11;
            cmd_err  <= 1'b0;
        end else begin
            cmd_err <= 1'b0;
            case (p_state)
                P_IDLE: begin
                    to_cnt   <= '0;
                    byte_idx <= '0;
                    led_buf  <= '0;
                    if (rx_valid) begin
                        case (rx_data)
                            OP_LED:  p_state <= P_LED;
                            OP_MODE: p_state <= P_MODE;
                            OP_RD:   p_state <= P_IDLE;
                            default: cmd_err <= 1'b1;
                        endcase
                    end
                end
                P_LED: begin
                    if (rx_valid) begin
                        to_cnt  <= '0;
                        led_buf <= led_next;
                        if (byte_idx == LAST_IDX) begin
                            led_reg <= led_next;
                            p_state <= P_IDLE;
                        end else begin
                            byte_idx <= byte_idx + 2'd1;
                        end
                    end else if (to_cnt == TO_LIM - 32'd1) begin
                        cmd_err <= 1'b1;
                        p_state <= P_IDLE;
                    end else begin
                        to_cnt <= to_cnt + 32'd1;
                    end
                end
                P_MODE: begin
                    if (rx_valid) begin
                        mode    <= rx_data[1:0];
                        p_state <= P_IDLE;
                    end else if (to_cnt == TO_LIM - 32'd1) begin
                        cmd_err <= 1'b1;
                        p_state <= P_IDLE;
                    end else begin
                        to_cnt <= to_cnt + 32'd1;
                    end
                end
                default: p_state <= P_IDLE;
            endcase
        end
    end

    assign idle_byte = rx_valid && (p_state == P_IDLE);
    assign rd_set    = idle_byte && (rx_data == OP_RD);
    assign err_set   = idle_byte && (rx_data != OP_LED) && (rx_data != OP_RD) && (rx_data != OP_MODE);
    assign rpt_set   = deb_load && mode[0];

    // Flag sets come first so a same-cycle frame selection clears them (coalescing).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            t_state     <= T_IDLE;
            tx_start    <= 1'b0;
            tx_data     <= '0;
            tx_left     <= '0;
            snap        <= '0;
            err_pending <= 1'b0;
            rd_pending  <= 1'b0;
            rpt_pending <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            if (err_set) err_pending <= 1'b1;
            if (rd_set)  rd_pending  <= 1'b1;
            if (rpt_set) rpt_pending <= 1'b1;
            case (t_state)
                T_IDLE: begin
                    if (!tx_busy && (err_pending || rd_pending || rpt_pending)) begin
                        tx_start <= 1'b1;
                        snap     <= sw_to_payload(sw_deb);
                        t_state  <= T_LAUNCH;
                        if (err_pending) begin
                            tx_data     <= RPL_ERR;
                            tx_left     <= '0;
                            err_pending <= 1'b0;
                        end else if (rd_pending) begin
                            tx_data    <= RPL_RD;
                            tx_left    <= PAY_LEN;
                            rd_pending <= 1'b0;
                        end else begin
                            tx_data     <= RPL_RPT;
                            tx_left     <= PAY_LEN;
                            rpt_pending <= 1'b0;
                        end
                    end
                end
                // Launch cycle doubles as the guard: the transmitter has not raised busy yet.
                T_LAUNCH: t_state <= T_WAIT;
                T_WAIT: begin
                    if (tx_left == 3'd0) begin
                        t_state <= T_IDLE;
                    end else if (!tx_busy) begin
                        tx_start <= 1'b1;
                        tx_data  <= snap[7:0];
                        snap     <= snap >> 8;
                        tx_left  <= tx_left - 3'd1;
                        t_state  <= T_LAUNCH;
                    end
                end
                default: t_state <= T_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_io_cmd_bridge.sv
// tb/tb_io_cmd_bridge.sv - scoreboard bench for io_cmd_bridge
module tb_io_cmd_bridge;
    localparam int SW_W  = 12;
    localparam int LED_W = 10;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [SW_W-1:0]  sw_in = '0;
    logic [LED_W-1:0] leds;
    logic [7:0]       rx_data = '0;
    logic             rx_valid = 1'b0;
    logic [7:0]       tx_data;
    logic             tx_start;
    logic             tx_busy = 1'b0;
    logic [1:0]       mode;
    logic             cmd_err;

    always #5 clk = ~clk;

    io_cmd_bridge #(
        .SW_WIDTH(SW_W), .LED_WIDTH(LED_W), .DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(100)
    ) dut (
        .clk(clk), .rst(rst), .sw_in(sw_in), .leds(leds),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
        .mode(mode), .cmd_err(cmd_err)
    );

    logic [7:0]  exp_q[$];
    logic [31:0] mon_exp;
    int n_cmp = 0, n_bad = 0;
    int err_seen = 0, e0 = 0;
    int busy_cnt = 0, cyc = 0, last_launch = -100;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, wanted %0h", name, act, exp);
        end
    endtask

    // Monitor and transmitter model: pop expected bytes on each launch, busy for 20 cycles after.
    initial forever begin
        @(negedge clk);
        cyc++;
        if (cmd_err === 1'b1) err_seen++;
        if (tx_start === 1'b1) begin
            check("launch_not_busy", {31'd0, tx_busy}, 32'd0);
            check("launch_spacing", {31'd0, (cyc - last_launch) >= 2}, 32'd1);
            last_launch = cyc;
            mon_exp = (exp_q.size() != 0) ? {24'd0, exp_q.pop_front()} : 32'h100;
            check("tx_byte", {24'd0, tx_data}, mon_exp);
            busy_cnt = 20;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
        end
        tx_busy = (busy_cnt != 0);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        rx_data = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data = 8'h00;
    endtask

    task automatic wait_q(input string name, input int target, input int limit);
        int k = 0;
        while (exp_q.size() > target && k < limit) begin
            @(negedge clk);
            k++;
        end
        check(name, exp_q.size(), target);
        if (exp_q.size() > target) exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(3);
        rst = 1'b0;
        check("rst_leds", leds, 0);
        check("rst_mode", mode, 3);
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_cmd_err", cmd_err, 0);

        // 1: mode write, full LED write
        send(8'hA2); send(8'h00);
        check("t1_mode", mode, 0);
        send(8'hA0); send(8'hFF); send(8'h03);
        check("t1_leds_n1", leds, 0);
        tick(1);
        check("t1_leds_n2", leds, 10'h3FF);

        // 2: truncated upper byte, then timeout mid-command
        send(8'hA0); send(8'h34); send(8'hFE);
        tick(1);
        check("t2_leds_trunc", leds, 10'h234);
        e0 = err_seen;
        send(8'hA0); send(8'h34);
        tick(90);
        check("t2_no_early_timeout", err_seen - e0, 0);
        tick(15);
        check("t2_timeout_err", err_seen - e0, 1);
        check("t2_leds_kept", leds, 10'h234);

        // 3: read reply, then merge mode
        sw_in = 12'hABC;
        tick(12);
        exp_q.push_back(8'hB1); exp_q.push_back(8'hBC); exp_q.push_back(8'h0A);
        send(8'hA1);
        check("t3_start_n1", tx_start, 0);
        tick(1);
        check("t3_start_n2", tx_start, 1);
        check("t3_hdr_n2", tx_data, 8'hB1);
        wait_q("t3_drained", 0, 200);
        tick(30);
        send(8'hA2); send(8'h02);
        check("t3_merge_n1", leds, 10'h234);
        tick(1);
        check("t3_merge_n2", leds, 10'h2BC);
        send(8'hA2); send(8'h00);
        tick(1);
        check("t3_unmerge", leds, 10'h234);

        // 4: glitch rejected, stable change reported once
        sw_in = 12'h000;
        tick(12);
        send(8'hA2); send(8'h01);
        check("t4_mode", mode, 1);
        sw_in = 12'h001;
        tick(3);
        sw_in = 12'h000;
        tick(30);
        exp_q.push_back(8'hB0); exp_q.push_back(8'h01); exp_q.push_back(8'h00);
        sw_in = 12'h001;
        tick(6);
        check("t4_deb_n6", tx_start, 0);
        tick(1);
        check("t4_deb_n7", tx_start, 1);
        check("t4_hdr", tx_data, 8'hB0);
        wait_q("t4_drained", 0, 200);
        tick(80);

        // 5: requests during an auto-report wait and are prioritised
        e0 = err_seen;
        exp_q.push_back(8'hB0); exp_q.push_back(8'h03); exp_q.push_back(8'h00);
        sw_in = 12'h003;
        wait_q("t5_report_started", 2, 50);
        exp_q.push_back(8'hEE);
        exp_q.push_back(8'hB1); exp_q.push_back(8'h03); exp_q.push_back(8'h00);
        send(8'hA1); send(8'hA1); send(8'h55);
        wait_q("t5_drained", 0, 400);
        tick(60);
        check("t5_one_err", err_seen - e0, 1);

        // 6: reset mid-frame
        send(8'hA2); send(8'h00);
        sw_in = 12'h000;
        tick(30);
        exp_q.push_back(8'hB1);
        send(8'hA1);
        wait_q("t6_first_byte", 0, 50);
        rst = 1'b1;
        #1;
        check("t6_tx_start", tx_start, 0);
        check("t6_leds", leds, 0);
        check("t6_mode", mode, 3);
        check("t6_tx_data", tx_data, 0);
        check("t6_cmd_err", cmd_err, 0);
        tick(2);
        rst = 1'b0;
        tick(100);
        check("t6_leds_after", leds, 0);
        check("end_queue_empty", exp_q.size(), 0);
        check("end_err_total", err_seen, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
